max7219_ctrl: RTL
=================

MAX7219_CTRL -- requirements
Module: max7219_ctrl

Interface
REQ-001 Parameter G_INTENSITY, default 4'h8: intensity register value sent during init.
REQ-002 Parameter G_SCAN_LIMIT, default 3'd7: scan-limit register value sent during init.
REQ-003 Parameter G_DECODE_MODE, default 8'h00: decode-mode register value sent during init.
REQ-004 Parameter G_TIMEOUT, default 4096: i_done watchdog limit in clk cycles (used only with REQ-027).
REQ-005 Port clk, input, 1: single clock; all logic rising-edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port i_init, input, 1: one-cycle request to run the init sequence.
REQ-008 Port i_wr_req, input, 1: digit write request; held high by the requester until o_wr_ack.
REQ-009 Port i_wr_addr, input, 3: digit index 0..7.
REQ-010 Port i_wr_data, input, 8: digit segment data.
REQ-011 Port o_wr_ack, output, 1: one-cycle pulse; the write request is captured.
REQ-012 Port o_init_done, output, 1: level; the init sequence has completed.
REQ-013 Port o_busy, output, 1: level; the state is not IDLE.
REQ-014 Port o_start, output, 1: one-cycle frame start to max7219_if.
REQ-015 Port o_en_load, output, 1: load enable to max7219_if.
REQ-016 Port o_data, output, 16: frame word to max7219_if.
REQ-017 Port i_done, input, 1: frame-complete pulse from max7219_if.
REQ-018 Port o_timeout, output, 1: one-cycle watchdog abort pulse.

Function
REQ-019 All outputs SHALL be registered; o_en_load SHALL be 1 whenever o_start is 1 and SHALL hold until i_done.
- FSM states: IDLE, SEND, WAIT_DONE, NEXT.
- IDLE -> SEND on a pending init or an accepted write.
- SEND: o_start=1 for exactly one cycle, then -> WAIT_DONE.
- WAIT_DONE -> NEXT on i_done.
- NEXT -> SEND if init words remain, else -> IDLE.
REQ-020 The init sequence SHALL send 6 words in this order:
- 16'h0C00
- {8'h09, G_DECODE_MODE}
- {8'h0A, 4'h0, G_INTENSITY}
- {8'h0B, 5'h00, G_SCAN_LIMIT}
- 16'h0F00
- 16'h0C01
REQ-021 A digit write SHALL send o_data = {4'h0, i_wr_addr+1 (4-bit), i_wr_data}, with o_wr_ack and o_start asserted in the same cycle, one cycle after the request is sampled in IDLE.
REQ-022 o_data SHALL be stable from the o_start cycle until the cycle i_done is sampled.
REQ-023 Priority and acceptance rules:
- i_init is latched as pending in any state and serviced from IDLE.
- When init and write are pending together in IDLE, init wins.
- Writes are accepted only while o_init_done=1 and the state is IDLE.
- Otherwise no ack is given and the requester holds i_wr_req.
REQ-024 On completion of the 6th init word, o_init_done SHALL set; on the start of any init sequence, o_init_done SHALL clear.
REQ-025 i_done received in IDLE, SEND or NEXT SHALL be ignored; i_init pulses arriving during an init sequence SHALL collapse into one pending request.

Reset
REQ-026 rst=1 at a clock edge SHALL force:
- state IDLE;
- init pointer 0 and pending-init flag cleared;
- o_start, o_en_load, o_wr_ack, o_init_done, o_busy and o_timeout all 0;
- o_data 16'h0000.
This applies even mid-frame; no frame is resumed after reset.

Configuration
REQ-027 With macro MAX7219_CTRL_TIMEOUT_EN defined:
- a counter SHALL run in WAIT_DONE;
- if i_done is absent for G_TIMEOUT cycles, the block SHALL pulse o_timeout, clear o_init_done, abandon the sequence and return to IDLE.
REQ-028 Without MAX7219_CTRL_TIMEOUT_EN:
- no counter is built;
- WAIT_DONE waits indefinitely;
- o_timeout is tied to 0.

Verification
REQ-029 Init sequence: pulse i_init, responder returns i_done 20 cycles after each o_start -> o_data words 0C00, 0900, 0A08, 0B07, 0F00, 0C01 in order; o_init_done=1 after the 6th i_done.
REQ-030 Digit write after init: i_wr_req=1, addr=3, data=8'hA5 -> next cycle o_wr_ack=1, o_start=1, o_data=16'h04A5.
REQ-031 Write before init: i_wr_req held with o_init_done=0 -> no o_wr_ack, no o_start; after init completes, ack follows.
REQ-032 Simultaneous events: i_init and i_wr_req in the same IDLE cycle -> first o_data=16'h0C00; ack only after 0C01 completes.
REQ-033 Reset mid-frame: rst=1 in WAIT_DONE of word 3 -> all outputs at reset values next cycle; o_init_done=0.
REQ-034 Watchdog, macro defined, G_TIMEOUT=64: i_done withheld -> o_timeout pulse 64 cycles after o_start, then IDLE; macro undefined -> o_busy stays 1 and o_timeout stays 0.

Source files
------------

// File: rtl/max7219_ctrl.sv
// MAX7219 frame sequencer: runs the six-word init sequence and digit writes toward max7219_if.
// Define MAX7219_CTRL_TIMEOUT_EN to build the i_done watchdog (G_TIMEOUT cycles).
module max7219_ctrl #(
   parameter logic [3:0]  G_INTENSITY   = 4'h8,
   parameter logic [2:0]  G_SCAN_LIMIT  = 3'd7,
   parameter logic [7:0]  G_DECODE_MODE = 8'h00,
   parameter int unsigned G_TIMEOUT     = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_init,
   input  logic        i_wr_req,
   input  logic [2:0]  i_wr_addr,
   input  logic [7:0]  i_wr_data,
   output logic        o_wr_ack,
   output logic        o_init_done,
   output logic        o_busy,
   output logic        o_start,
   output logic        o_en_load,
   output logic [15:0] o_data,
   input  logic        i_done,
   output logic        o_timeout
);

   localparam int unsigned PTR_W = 3;
   localparam logic [PTR_W-1:0] LAST_INIT = PTR_W'(5);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, NEXT} state_t;

   state_t           state;
   logic [PTR_W-1:0] init_ptr;
   logic             init_pend;
   logic             in_init;

`ifdef MAX7219_CTRL_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(G_TIMEOUT + 1);
   logic [CNT_W-1:0] wdog_cnt;
`else
   logic unused_timeout_c;
   assign unused_timeout_c = ^G_TIMEOUT;
`endif

   // Init word table: display off, decode, intensity, scan limit, test off, display on.
   function automatic logic [15:0] init_word(input logic [PTR_W-1:0] idx);
      case (idx)
         3'd0:    return 16'h0C00;
         3'd1:    return {8'h09, G_DECODE_MODE};
         3'd2:    return {8'h0A, 4'h0, G_INTENSITY};
         3'd3:    return {8'h0B, 5'h00, G_SCAN_LIMIT};
         3'd4:    return 16'h0F00;
         default: return 16'h0C01;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         init_ptr    <= '0;
         init_pend   <= 1'b0;
         in_init     <= 1'b0;
         o_wr_ack    <= 1'b0;
         o_init_done <= 1'b0;
         o_busy      <= 1'b0;
         o_start     <= 1'b0;
         o_en_load   <= 1'b0;
         o_data      <= 16'h0000;
         o_timeout   <= 1'b0;
`ifdef MAX7219_CTRL_TIMEOUT_EN
         wdog_cnt    <= '0;
`endif
      end else begin
         o_start   <= 1'b0;
         o_wr_ack  <= 1'b0;
         o_timeout <= 1'b0;
         if (i_init && state != IDLE) init_pend <= 1'b1;

         case (state)
            IDLE: begin
               if (init_pend || i_init) begin
                  init_pend   <= 1'b0;
                  in_init     <= 1'b1;
                  init_ptr    <= '0;
                  o_init_done <= 1'b0;
                  o_data      <= init_word(PTR_W'(0));
                  o_start     <= 1'b1;
                  o_en_load   <= 1'b1;
                  o_busy      <= 1'b1;
                  state       <= SEND;
               end else if (i_wr_req && o_init_done) begin
                  o_data    <= {4'h0, (4'(i_wr_addr) + 4'd1), i_wr_data};
                  o_wr_ack  <= 1'b1;
                  o_start   <= 1'b1;
                  o_en_load <= 1'b1;
                  o_busy    <= 1'b1;
                  state     <= SEND;
               end
            end

            SEND: begin
`ifdef MAX7219_CTRL_TIMEOUT_EN
               wdog_cnt <= CNT_W'(1);
`endif
               state <= WAIT_DONE;
            end

            WAIT_DONE: begin
               if (i_done) begin
                  o_en_load <= 1'b0;
                  if (in_init && init_ptr == LAST_INIT) o_init_done <= 1'b1;
                  state <= NEXT;
               end
`ifdef MAX7219_CTRL_TIMEOUT_EN
               // Counter measures cycles since the o_start cycle.
               else if (wdog_cnt == CNT_W'(G_TIMEOUT - 1)) begin
                  o_timeout   <= 1'b1;
                  o_init_done <= 1'b0;
                  o_en_load   <= 1'b0;
                  o_busy      <= 1'b0;
                  in_init     <= 1'b0;
                  init_ptr    <= '0;
                  state       <= IDLE;
               end else begin
                  wdog_cnt <= wdog_cnt + CNT_W'(1);
               end
`endif
            end

            NEXT: begin
               if (in_init && init_ptr != LAST_INIT) begin
                  init_ptr  <= init_ptr + PTR_W'(1);
                  o_data    <= init_word(init_ptr + PTR_W'(1));
                  o_start   <= 1'b1;
                  o_en_load <= 1'b1;
                  state     <= SEND;
               end else begin
                  in_init <= 1'b0;
                  o_busy  <= 1'b0;
                  state   <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
